// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, scan state type and hex-to-segment table for the
// seven-segment scan controller.
package seg_pkg;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] ANODE_OFF  = 4'hF;
  localparam int         NUM_DIGITS = 4;

  typedef enum logic {
    ST_ON,
    ST_GAP
  } scan_state_e;

  // Active-low {g,f,e,d,c,b,a}, indexed by hex nibble value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_scan_ctrl_hex_to_seg.sv
// Combinational hex nibble to active-low seven-segment pattern.
module hex_to_seg
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[hex];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode scan controller: double-buffered value load,
// digit rotation with blank gap, registered pin drivers.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int GAP_CYCLES  = 16,
  parameter int CNT_W       = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [15:0] value_in,
  input  logic [3:0]  dp_in,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic        blank_lz,
  output logic [3:0]  anode,
  output logic [6:0]  seg,
  output logic        dp,
  output logic [1:0]  digit_sel,
  output logic        frame_done
);

  localparam logic [CNT_W-1:0] REF_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  // load handshake: a transfer happens on any edge where load_valid && load_ready;
  // load_ready depends only on the registered pending flag.
  scan_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [1:0]       digit_n;
  logic             advance;

  logic [15:0] pend_val, act_val;
  logic [3:0]  pend_dp, act_dp;
  logic        pend_full;
  logic        xfer, swap;

  logic [3:0]            nibble;
  logic [6:0]            dec_seg;
  logic [NUM_DIGITS-1:0] lz_zero;
  logic                  lz_blank;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_ON;
      cnt       <= '0;
      digit_sel <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      digit_sel <= digit_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    digit_n = digit_sel;
    advance = 1'b0;
    if (!enable) begin
      state_n = ST_ON;
      cnt_n   = '0;
      digit_n = '0;
    end else begin
      case (state)
        ST_ON: begin
          if (cnt == REF_LAST) begin
            cnt_n = '0;
            if (GAP_CYCLES == 0) advance = 1'b1;
            else                 state_n = ST_GAP;
          end
        end
        ST_GAP: begin
          if (cnt == GAP_LAST) begin
            cnt_n   = '0;
            state_n = ST_ON;
            advance = 1'b1;
          end
        end
        default: begin
          state_n = ST_ON;
          cnt_n   = '0;
        end
      endcase
      if (advance) digit_n = digit_sel + 2'd1;
    end
  end

  assign frame_done = advance && (digit_sel == 2'd3);

  assign load_ready = !pend_full;
  assign xfer       = load_valid && load_ready;
  // Swapping only at frame end (or while dark) keeps a frame from mixing two values.
  assign swap       = pend_full && (frame_done || !enable);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_val  <= '0;
      pend_dp   <= '0;
      pend_full <= 1'b0;
      act_val   <= '0;
      act_dp    <= '0;
    end else begin
      if (swap) begin
        act_val <= pend_val;
        act_dp  <= pend_dp;
      end
      if (xfer) begin
        pend_val <= value_in;
        pend_dp  <= dp_in;
      end
      if (xfer)      pend_full <= 1'b1;
      else if (swap) pend_full <= 1'b0;
    end
  end

  assign nibble = act_val[{digit_sel, 2'b00} +: 4];

  hex_to_seg u_dec (
    .hex (nibble),
    .seg (dec_seg)
  );

  // lz_zero[k]: nibbles 3..k of the active value are all zero.
  always_comb begin
    lz_zero[3] = (act_val[15:12] == 4'h0);
    lz_zero[2] = lz_zero[3] && (act_val[11:8] == 4'h0);
    lz_zero[1] = lz_zero[2] && (act_val[7:4] == 4'h0);
    lz_zero[0] = 1'b0;
  end

  assign lz_blank = blank_lz && lz_zero[digit_sel];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      anode <= ANODE_OFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else if (!enable || state != ST_ON) begin
      anode <= ANODE_OFF;
      seg   <= SEG_BLANK;
      dp    <= 1'b1;
    end else begin
      anode <= ~(4'b0001 << digit_sel);
      seg   <= lz_blank ? SEG_BLANK : dec_seg;
      dp    <= ~act_dp[digit_sel];
    end
  end

endmodule
